fft4_input_framer: RTL and testbench
====================================

Name:
fft4_input_framer

Overview:
Upstream stage of the 4-point radix-2 FFT core. It accepts a serial stream of complex samples over a valid/ready handshake and groups them into 4-sample frames in natural order (x0..x3). It presents each complete frame in parallel to the combinational FFT inputs. A ping-pong frame buffer sustains 1 sample/cycle while the downstream stage consumes frames.

Parameters:
WIDTH, 16, bit width of each real/imag component; two's complement signed

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous clear of the partial frame and both stored frames
in_valid  input  1  input sample valid
in_ready  output  1  framer can accept a sample this cycle
in_last  input  1  marks the final sample of a frame; qualified by in_valid&&in_ready
in_r  input  WIDTH  sample real part
in_i  input  WIDTH  sample imaginary part
out_valid  output  1  a complete frame is presented on x*_r/x*_i
out_ready  input  1  downstream consumes the frame this cycle
x0_r, x0_i  output  WIDTH each  frame sample 0 (first accepted)
x1_r, x1_i  output  WIDTH each  frame sample 1
x2_r, x2_i  output  WIDTH each  frame sample 2
x3_r, x3_i  output  WIDTH each  frame sample 3 (last accepted)
align_err  output  1  one-cycle pulse: in_last seen before the 4th sample

Behaviour:
- State: two banks of 4 complex registers; wr_bank, wr_idx[1:0], rd_bank, full[1:0].
- Reset (async): wr_bank=0, rd_bank=0, wr_idx=0, full=00, all bank registers 0, align_err=0. As a result, in_ready=1, out_valid=0, and all x* outputs are 0.
- in_ready = !full[wr_bank], combinational from registers only; it never depends on in_valid.
- Accept happens when in_valid&&in_ready. The sample is written to bank[wr_bank][wr_idx].
  - If wr_idx==3: set full[wr_bank], toggle wr_bank, and set wr_idx=0. in_last may be 0 or 1 here; there is no error either way.
  - If wr_idx<3 and in_last=0: increment wr_idx.
  - If wr_idx<3 and in_last=1: discard the partial frame (wr_idx=0, no full set), and pulse align_err the next cycle.
- out_valid = full[rd_bank]. x* outputs are driven from bank[rd_bank] and are stable while out_valid=1 && !out_ready.
- Consume happens when out_valid&&out_ready: clear full[rd_bank] and toggle rd_bank.
- Latency: out_valid rises the cycle after the 4th sample is accepted, if that bank is rd_bank; otherwise it rises as soon as the prior frame is consumed.
- Fill and drain in the same cycle always target different banks, and both take effect.
- When both banks are full, in_ready=0. A consume frees a bank for writing; in_ready returns to 1 the next cycle.
- Throughput: with out_ready held high, the block sustains 1 sample/cycle with in_ready constantly 1.
- flush (synchronous, higher priority than accept/consume): sets wr_idx=0, full=00, wr_bank=rd_bank=0. Bank data need not be cleared. A sample presented in the flush cycle is dropped. align_err is not asserted.
- Reset mid-frame discards all data immediately; outputs return to reset values asynchronously.
- No arithmetic is performed; data passes bit-exact with no sign extension.

Decomposition:
- Shared package fft_pkg:
  - WIDTH default
  - complex sample struct {re, im}
  - FFT_N=4 and its log2 constant
  - frame index type
- Natural sub-module: fft_frame_bank (4-entry complex register bank with write-enable/index and parallel read). Instantiate it twice for ping-pong, with a rd_bank mux on the outputs.

Test Plan:
1. Reset then stream (1,-1),(2,-2),(3,-3),(4,-4) with in_last on the 4th sample, out_ready=1 -> out_valid=1 for exactly 1 cycle, 1 cycle after the 4th accept, with x0=(1,-1) and x3=(4,-4). The FFT golden model gives y0=(10,-10).
2. Continuous 12 samples (values 0..11, re=im), out_ready=1 -> in_ready constantly 1 and 3 frames out: {0..3},{4..7},{8..11} in order.
3. out_ready=0, push 8 samples -> both banks full and in_ready=0 after the 8th accept. The 9th sample is held. Raising out_ready releases frame {0..3}, then {4..7}, and in_ready=1 the cycle after the first consume.
4. in_last asserted on the 2nd sample -> align_err pulses once, no frame is output, and the next 4 samples form a correctly aligned frame.
5. out_valid=1 with out_ready toggling 0/1 randomly -> x* outputs stay stable while stalled, and no frame is duplicated or lost.
6. Assert rst asynchronously mid-frame (after 2 samples), and separately flush with 1 full bank -> out_valid=0 and in_ready=1 immediately/next cycle; the following frame of 4 samples outputs correctly.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants and types for the 4-point radix-2 FFT datapath.
package fft_pkg;
    localparam int DEFAULT_WIDTH = 16;
    localparam int FFT_N         = 4;
    localparam int FFT_LOG2N     = 2;

    typedef logic [FFT_LOG2N-1:0] frame_idx_t;

    typedef struct packed {
        logic signed [DEFAULT_WIDTH-1:0] re;
        logic signed [DEFAULT_WIDTH-1:0] im;
    } cplx_t;
endpackage

// File: rtl/fft_frame_bank.sv
// One 4-entry complex register bank: indexed single-sample write, full parallel read.
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  frame_idx_t                    wr_idx,
    input  logic [WIDTH-1:0]              wr_r,
    input  logic [WIDTH-1:0]              wr_i,
    output logic [FFT_N-1:0][WIDTH-1:0]   rd_r,
    output logic [FFT_N-1:0][WIDTH-1:0]   rd_i
);
    logic [FFT_N-1:0][WIDTH-1:0] data_r_q, data_r_d;
    logic [FFT_N-1:0][WIDTH-1:0] data_i_q, data_i_d;

    always_comb begin
        data_r_d = data_r_q;
        data_i_d = data_i_q;
        if (wr_en) begin
            data_r_d[wr_idx] = wr_r;
            data_i_d[wr_idx] = wr_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r_q <= '0;
            data_i_q <= '0;
        end else begin
            data_r_q <= data_r_d;
            data_i_q <= data_i_d;
        end
    end

    assign rd_r = data_r_q;
    assign rd_i = data_i_q;
endmodule

// File: rtl/fft4_input_framer.sv
// Groups a serial valid/ready complex sample stream into 4-sample frames using a
// ping-pong pair of banks, presenting the oldest complete frame in parallel.
module fft4_input_framer
    import fft_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [WIDTH-1:0] in_r,
    input  logic [WIDTH-1:0] in_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x0_r,
    output logic [WIDTH-1:0] x0_i,
    output logic [WIDTH-1:0] x1_r,
    output logic [WIDTH-1:0] x1_i,
    output logic [WIDTH-1:0] x2_r,
    output logic [WIDTH-1:0] x2_i,
    output logic [WIDTH-1:0] x3_r,
    output logic [WIDTH-1:0] x3_i,
    output logic             align_err
);
    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    frame_idx_t wr_idx_q,  wr_idx_d;
    logic [1:0] full_q,    full_d;
    logic       align_err_q, align_err_d;

    logic       accept;
    logic       consume;
    logic [1:0] bank_we;
    logic [1:0][FFT_N-1:0][WIDTH-1:0] bank_r;
    logic [1:0][FFT_N-1:0][WIDTH-1:0] bank_i;

    assign in_ready  = !full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;
    assign align_err = align_err_q;

    // Fill and drain can never hit the same bank: fill needs it empty, drain needs it full.
    always_comb begin
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_idx_d    = wr_idx_q;
        full_d      = full_q;
        align_err_d = 1'b0;
        bank_we     = '0;
        if (flush) begin
            wr_bank_d = 1'b0;
            rd_bank_d = 1'b0;
            wr_idx_d  = '0;
            full_d    = '0;
        end else begin
            if (accept) begin
                bank_we[wr_bank_q] = 1'b1;
                if (wr_idx_q == frame_idx_t'(FFT_N - 1)) begin
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = !wr_bank_q;
                    wr_idx_d          = '0;
                end else if (in_last) begin
                    wr_idx_d    = '0;
                    align_err_d = 1'b1;
                end else begin
                    wr_idx_d = wr_idx_q + frame_idx_t'(1);
                end
            end
            if (consume) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            full_q      <= '0;
            align_err_q <= 1'b0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_idx_q    <= wr_idx_d;
            full_q      <= full_d;
            align_err_q <= align_err_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_frame_bank #(.WIDTH(WIDTH)) u_bank (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (bank_we[b]),
            .wr_idx (wr_idx_q),
            .wr_r   (in_r),
            .wr_i   (in_i),
            .rd_r   (bank_r[b]),
            .rd_i   (bank_i[b])
        );
    end

    assign x0_r = bank_r[rd_bank_q][0];
    assign x0_i = bank_i[rd_bank_q][0];
    assign x1_r = bank_r[rd_bank_q][1];
    assign x1_i = bank_i[rd_bank_q][1];
    assign x2_r = bank_r[rd_bank_q][2];
    assign x2_i = bank_i[rd_bank_q][2];
    assign x3_r = bank_r[rd_bank_q][3];
    assign x3_i = bank_i[rd_bank_q][3];
endmodule

// File: tb/tb_fft4_input_framer.sv
// Directed bench for fft4_input_framer: per-cycle vector table plus hand-written
// sequences for random stalls, asynchronous reset and flush.
module tb_fft4_input_framer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_last = 1'b0;
    logic [15:0] in_r = '0;
    logic [15:0] in_i = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] x0_r, x0_i, x1_r, x1_i, x2_r, x2_i, x3_r, x3_i;
    logic        align_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string name;
        logic  iv;
        logic  il;
        int    r;
        int    i;
        logic  ordy;
        logic  eir;
        logic  eov;
        logic  eae;
        int    e0r;
        int    e0i;
        int    e3r;
        int    e3i;
    } vec_t;

    vec_t vecs[$];

    fft4_input_framer #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_r      (in_r),
        .in_i      (in_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x0_r      (x0_r),
        .x0_i      (x0_i),
        .x1_r      (x1_r),
        .x1_i      (x1_i),
        .x2_r      (x2_r),
        .x2_i      (x2_i),
        .x3_r      (x3_r),
        .x3_i      (x3_i),
        .align_err (align_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {16'(a), 16'(b), 16'(c), 16'(d)};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic il, input int r, input int i,
                                 input logic ordy, input logic fl);
        in_valid  = iv;
        in_last   = il;
        in_r      = 16'(r);
        in_i      = 16'(i);
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic addVec(input string nm, input logic iv, input logic il, input int r, input int i,
                          input logic ordy, input logic eir, input logic eov, input logic eae,
                          input int e0r = 0, input int e0i = 0, input int e3r = 0, input int e3i = 0);
        vec_t v;
        v.name = nm; v.iv = iv; v.il = il; v.r = r; v.i = i; v.ordy = ordy;
        v.eir = eir; v.eov = eov; v.eae = eae;
        v.e0r = e0r; v.e0i = e0i; v.e3r = e3r; v.e3i = e3i;
        vecs.push_back(v);
    endtask

    task automatic pushFrame(input int base, input logic ordy);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            applyStimulus(1'b1, k == 3, base + k, -(base + k), ordy, 1'b0);
        end
    endtask

    task automatic checkFrame(input string name, input int base);
        checkOutput({name, " out_valid"}, 64'(out_valid), 64'(1));
        checkOutput({name, " re"}, {x0_r, x1_r, x2_r, x3_r}, pack4(base, base + 1, base + 2, base + 3));
        checkOutput({name, " im"}, {x0_i, x1_i, x2_i, x3_i},
                    pack4(-base, -(base + 1), -(base + 2), -(base + 3)));
    endtask

    initial begin
        // Single frame; in_last on the 4th sample is legal.
        addVec("t1 s0", 1, 0, 1, -1, 1, 1, 0, 0);
        addVec("t1 s1", 1, 0, 2, -2, 1, 1, 0, 0);
        addVec("t1 s2", 1, 0, 3, -3, 1, 1, 0, 0);
        addVec("t1 s3", 1, 1, 4, -4, 1, 1, 0, 0);
        addVec("t1 out", 0, 0, 0, 0, 1, 1, 1, 0, 1, -1, 4, -4);
        addVec("t1 idle", 0, 0, 0, 0, 1, 1, 0, 0);
        // Continuous streaming, three frames, in_ready never drops.
        for (int v = 0; v < 12; v++)
            addVec($sformatf("t2 s%0d", v), 1, (v % 4) == 3, v, v, 1, 1, (v == 4) || (v == 8), 0,
                   v - 4, v - 4, v - 1, v - 1);
        addVec("t2 out", 0, 0, 0, 0, 1, 1, 1, 0, 8, 8, 11, 11);
        addVec("t2 idle", 0, 0, 0, 0, 1, 1, 0, 0);
        // Early in_last discards the partial frame, then a clean frame follows.
        addVec("t4 a0", 1, 0, 20, 20, 1, 1, 0, 0);
        addVec("t4 a1", 1, 1, 21, 21, 1, 1, 0, 0);
        addVec("t4 b0", 1, 0, 30, 30, 1, 1, 0, 1);
        addVec("t4 b1", 1, 0, 31, 31, 1, 1, 0, 0);
        addVec("t4 b2", 1, 0, 32, 32, 1, 1, 0, 0);
        addVec("t4 b3", 1, 1, 33, 33, 1, 1, 0, 0);
        addVec("t4 out", 0, 0, 0, 0, 1, 1, 1, 0, 30, 30, 33, 33);
        addVec("t4 idle", 0, 0, 0, 0, 1, 1, 0, 0);
        // Backpressure: both banks fill, 9th sample waits for a consume.
        for (int v = 40; v < 48; v++)
            addVec($sformatf("t3 s%0d", v), 1, (v % 4) == 3, v, -v, 0, 1, v >= 44, 0, 40, -40, 43, -43);
        addVec("t3 hold0", 1, 0, 48, -48, 0, 0, 1, 0, 40, -40, 43, -43);
        addVec("t3 hold1", 1, 0, 48, -48, 1, 0, 1, 0, 40, -40, 43, -43);
        addVec("t3 s48", 1, 0, 48, -48, 0, 1, 1, 0, 44, -44, 47, -47);
        addVec("t3 s49", 1, 0, 49, -49, 1, 1, 1, 0, 44, -44, 47, -47);
        addVec("t3 s50", 1, 0, 50, -50, 1, 1, 0, 0);
        addVec("t3 s51", 1, 1, 51, -51, 1, 1, 0, 0);
        addVec("t3 out", 0, 0, 0, 0, 1, 1, 1, 0, 48, -48, 51, -51);
        addVec("t3 idle", 0, 0, 0, 0, 1, 1, 0, 0);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset in_ready", 64'(in_ready), 64'(1));
        checkOutput("reset out_valid", 64'(out_valid), 64'(0));
        checkOutput("reset align_err", 64'(align_err), 64'(0));
        checkOutput("reset x re", {x0_r, x1_r, x2_r, x3_r}, 64'(0));
        checkOutput("reset x im", {x0_i, x1_i, x2_i, x3_i}, 64'(0));

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            checkOutput({vecs[k].name, " in_ready"}, 64'(in_ready), 64'(vecs[k].eir));
            checkOutput({vecs[k].name, " out_valid"}, 64'(out_valid), 64'(vecs[k].eov));
            checkOutput({vecs[k].name, " align_err"}, 64'(align_err), 64'(vecs[k].eae));
            if (vecs[k].eov)
                checkOutput({vecs[k].name, " x0/x3"}, {x0_r, x0_i, x3_r, x3_i},
                            pack4(vecs[k].e0r, vecs[k].e0i, vecs[k].e3r, vecs[k].e3i));
            applyStimulus(vecs[k].iv, vecs[k].il, vecs[k].r, vecs[k].i, vecs[k].ordy, 1'b0);
        end

        // Random out_ready: frames must arrive in order, unchanged while stalled.
        begin
            int          sent = 0;
            int          got = 0;
            logic        stalled = 1'b0;
            logic        ordy;
            logic [63:0] held_r = '0;
            logic [63:0] held_i = '0;
            for (int cyc = 0; cyc < 300 && got < 3; cyc++) begin
                @(negedge clk);
                if (stalled) begin
                    checkOutput("t5 stall valid", 64'(out_valid), 64'(1));
                    checkOutput("t5 stall re", {x0_r, x1_r, x2_r, x3_r}, held_r);
                    checkOutput("t5 stall im", {x0_i, x1_i, x2_i, x3_i}, held_i);
                end
                ordy = 1'($urandom_range(0, 1));
                if (out_valid && ordy) begin
                    checkFrame($sformatf("t5 frame%0d", got), 100 + 4 * got);
                    got++;
                end
                stalled = out_valid && !ordy;
                held_r  = {x0_r, x1_r, x2_r, x3_r};
                held_i  = {x0_i, x1_i, x2_i, x3_i};
                applyStimulus(sent < 12, (sent % 4) == 3, 100 + sent, -(100 + sent), ordy, 1'b0);
                if (in_valid && in_ready) sent++;
            end
            checkOutput("t5 frame count", 64'(got), 64'(3));
            @(negedge clk);
            checkOutput("t5 no duplicate", 64'(out_valid), 64'(0));
            applyStimulus(0, 0, 0, 0, 0, 0);
        end

        // Asynchronous reset with one stored frame and a half-written one.
        pushFrame(60, 1'b0);
        @(negedge clk); applyStimulus(1, 0, 64, -64, 0, 0);
        @(negedge clk); applyStimulus(1, 0, 65, -65, 0, 0);
        @(negedge clk); applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t6 pre-reset out_valid", 64'(out_valid), 64'(1));
        #2 rst = 1'b1;
        #1;
        checkOutput("t6 async out_valid", 64'(out_valid), 64'(0));
        checkOutput("t6 async in_ready", 64'(in_ready), 64'(1));
        checkOutput("t6 async x re", {x0_r, x1_r, x2_r, x3_r}, 64'(0));
        @(negedge clk);
        rst = 1'b0;
        pushFrame(70, 1'b1);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkFrame("t6 after reset", 70);
        @(negedge clk);
        checkOutput("t6 after reset drained", 64'(out_valid), 64'(0));

        // Flush with one full bank; the flush-cycle sample (with in_last) is dropped silently.
        pushFrame(80, 1'b0);
        @(negedge clk);
        checkOutput("t6 pre-flush out_valid", 64'(out_valid), 64'(1));
        applyStimulus(1, 1, 99, -99, 0, 1);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t6 flush out_valid", 64'(out_valid), 64'(0));
        checkOutput("t6 flush in_ready", 64'(in_ready), 64'(1));
        checkOutput("t6 flush align_err", 64'(align_err), 64'(0));
        pushFrame(84, 1'b1);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkFrame("t6 after flush", 84);
        @(negedge clk);
        checkOutput("t6 after flush drained", 64'(out_valid), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
